// File: rtl/alu_multiword_seq.sv
// -----------------------------------------------------------------------------
// alu_multiword_seq
//
// Purpose:
//   Runs an N-word (up to MAX_WORDS x 32-bit) ADD/SUB on a shared 32-bit ALU.
//   One ALU operation is issued per word, least-significant word first, and
//   the carry is chained through the ALU carry input. The block fetches the
//   operand words from the register file and drives the ALU. It then writes
//   each result word back. While busy it owns the ALU input mux.
//
// Optional feature (compile-time macro ALU_MW_CMP_EN):
//   defined   : op=2'b10 (CMP) sequences exactly like SUB but never writes;
//               only flags_out is updated.
//   undefined : op=2'b10 behaves as SUB, including the writes.
//
// Ports:
//   CLK, RESETn             clock (rising edge) and async active-low reset
//   start, op, nwords       request strobe (sampled in IDLE), opcode, word count
//   base_a, base_b, base_d  word-0 addresses of A, B and destination
//   abort                   cancels the operation in progress
//   rd_addr_a/b, rd_data_a/b  register-file read ports (1-cycle read latency)
//   alu_src_a/b, alu_control, alu_c_in   ALU operand/control drive
//   alu_result, alu_flags   ALU result and {N,Z,C,V}
//   wr_en, wr_addr, wr_data result write port
//   busy, done, flags_out   status, completion pulse, final {N,Z,C,V}
// -----------------------------------------------------------------------------
module alu_multiword_seq #(
    parameter int MAX_WORDS = 4,
    parameter int AW        = 4,
    localparam int NW       = $clog2(MAX_WORDS + 1)
) (
    input  logic          CLK,
    input  logic          RESETn,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [NW-1:0] nwords,
    input  logic [AW-1:0] base_a,
    input  logic [AW-1:0] base_b,
    input  logic [AW-1:0] base_d,
    input  logic          abort,
    output logic [AW-1:0] rd_addr_a,
    output logic [AW-1:0] rd_addr_b,
    input  logic [31:0]   rd_data_a,
    input  logic [31:0]   rd_data_b,
    output logic [31:0]   alu_src_a,
    output logic [31:0]   alu_src_b,
    output logic [3:0]    alu_control,
    output logic          alu_c_in,
    input  logic [31:0]   alu_result,
    input  logic [3:0]    alu_flags,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [31:0]   wr_data,
    output logic          busy,
    output logic          done,
    output logic [3:0]    flags_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0100;
    localparam logic [3:0] ALU_ADC = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_SBC = 4'b0110;

    // Requests larger than MAX_WORDS are clamped rather than rejected.
    function automatic logic [NW-1:0] clamp_words(input logic [NW-1:0] req);
        logic [NW-1:0] lim;
        lim = NW'(MAX_WORDS);
        if (req > lim) begin
            return lim;
        end else begin
            return req;
        end
    endfunction

    state_t        state_q,  state_d;
    logic [1:0]    op_q,     op_d;
    logic [AW-1:0] base_a_q, base_a_d;
    logic [AW-1:0] base_b_q, base_b_d;
    logic [AW-1:0] base_d_q, base_d_d;
    logic [NW-1:0] n_q,      n_d;
    logic [NW-1:0] i_q,      i_d;
    logic          c_q,      c_d;      // carry of the previous word
    logic          cz_q,     cz_d;     // AND of every per-word Z so far
    logic [3:0]    flags_q,  flags_d;
    logic          busy_q,   busy_d;
    logic          done_q,   done_d;
    logic [AW-1:0] rda_q,    rda_d;
    logic [AW-1:0] rdb_q,    rdb_d;

    logic          is_sub_s;
    logic          no_write_s;
    logic [NW-1:0] n_req_s;
    logic [NW-1:0] i_next_s;
    logic          last_word_s;

    assign is_sub_s    = (op_q == 2'b01) || (op_q == 2'b10);
    assign n_req_s     = clamp_words(nwords);
    assign i_next_s    = i_q + NW'(1);
    assign last_word_s = (i_q == (n_q - NW'(1)));

`ifdef ALU_MW_CMP_EN
    assign no_write_s = (op_q == 2'b10);
`else
    assign no_write_s = 1'b0;
`endif

    // Next-state and registered-output computation for the sequencer FSM.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        base_a_d = base_a_q;
        base_b_d = base_b_q;
        base_d_d = base_d_q;
        n_d      = n_q;
        i_d      = i_q;
        c_d      = c_q;
        cz_d     = cz_q;
        flags_d  = flags_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        rda_d    = {AW{1'b0}};
        rdb_d    = {AW{1'b0}};

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d     = op;
                    base_a_d = base_a;
                    base_b_d = base_b;
                    base_d_d = base_d;
                    n_d      = n_req_s;
                    i_d      = {NW{1'b0}};
                    c_d      = 1'b0;
                    cz_d     = 1'b1;
                    if (n_req_s == {NW{1'b0}}) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_FETCH;
                        busy_d  = 1'b1;
                        rda_d   = base_a;
                        rdb_d   = base_b;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_EXEC;
                    busy_d  = 1'b1;
                end
            end
            ST_EXEC: begin
                // abort wins over completion: no flag update, no done.
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    c_d  = alu_flags[1];
                    cz_d = cz_q & alu_flags[2];
                    if (last_word_s) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        flags_d = {alu_flags[3], cz_q & alu_flags[2],
                                   alu_flags[1], alu_flags[0]};
                    end else begin
                        i_d     = i_next_s;
                        state_d = ST_FETCH;
                        busy_d  = 1'b1;
                        rda_d   = base_a_q + AW'(i_next_s);
                        rdb_d   = base_b_q + AW'(i_next_s);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered-output flops with asynchronous reset.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q  <= ST_IDLE;
            op_q     <= 2'b00;
            base_a_q <= {AW{1'b0}};
            base_b_q <= {AW{1'b0}};
            base_d_q <= {AW{1'b0}};
            n_q      <= {NW{1'b0}};
            i_q      <= {NW{1'b0}};
            c_q      <= 1'b0;
            cz_q     <= 1'b1;
            flags_q  <= 4'b0000;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rda_q    <= {AW{1'b0}};
            rdb_q    <= {AW{1'b0}};
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            base_a_q <= base_a_d;
            base_b_q <= base_b_d;
            base_d_q <= base_d_d;
            n_q      <= n_d;
            i_q      <= i_d;
            c_q      <= c_d;
            cz_q     <= cz_d;
            flags_q  <= flags_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rda_q    <= rda_d;
            rdb_q    <= rdb_d;
        end
    end

    // ALU drive and write-back; the ALU result is consumed in the same cycle.
    always_comb begin
        alu_src_a   = 32'h0000_0000;
        alu_src_b   = 32'h0000_0000;
        alu_control = 4'b0000;
        alu_c_in    = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = {AW{1'b0}};
        wr_data     = 32'h0000_0000;
        if (state_q == ST_EXEC) begin
            alu_src_a = rd_data_a;
            alu_src_b = rd_data_b;
            // First word has no incoming carry; later words chain the
            // registered carry (ARM convention: C=1 means no borrow).
            if (i_q == {NW{1'b0}}) begin
                alu_control = is_sub_s ? ALU_SUB : ALU_ADD;
                alu_c_in    = 1'b0;
            end else begin
                alu_control = is_sub_s ? ALU_SBC : ALU_ADC;
                alu_c_in    = c_q;
            end
            wr_en   = ~abort & ~no_write_s;
            wr_addr = base_d_q + AW'(i_q);
            wr_data = alu_result;
        end else begin
            wr_en = 1'b0;
        end
    end

    assign rd_addr_a = rda_q;
    assign rd_addr_b = rdb_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign flags_out = flags_q;

endmodule
